// File: rtl/keypad_pkg.sv
// +-----------------------------------------------------------------------+
// | keypad_pkg : shared types and key map for the 4x4 keypad scanner     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // Entry {row,col} lives at bits [4*{row,col} +: 4]; '*' encodes as E, '#' as F.
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] idx;
    idx = {row, col};
    return KEY_MAP[idx*4 +: 4];
  endfunction

endpackage

`default_nettype wire

// File: rtl/scan_tick_gen.sv
// +-----------------------------------------------------------------------+
// | scan_tick_gen : free-running prescaler, one-clk tick per scan period  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module scan_tick_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int SCAN_HZ = 1_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int TC = CLK_HZ / SCAN_HZ - 1;
  localparam int W  = (TC > 0) ? $clog2(TC + 1) : 1;
  localparam logic [W-1:0] TC_W = W'(TC);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    tick    = (count_q == TC_W);
    count_d = tick ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// +-----------------------------------------------------------------------+
// | keypad_scanner : 4x4 matrix scan, debounce, hex encode, digit shifter |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int SCAN_HZ        = 1_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_held,
  output logic [15:0] digits
);

  localparam logic [3:0] DEB_N = 4'(DEBOUNCE_SCANS);

  logic tick;

  scan_tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .SCAN_HZ (SCAN_HZ)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  state_e          state_q, state_d;
  logic [ROWS-1:0] sync1_q, sync1_d;
  logic [ROWS-1:0] rs_q, rs_d;
  logic [1:0]      col_q, col_d;
  logic [1:0]      row_q, row_d;
  logic [3:0]      deb_q, deb_d;
  logic            key_valid_q, key_valid_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_held_q, key_held_d;
  logic [15:0]     digits_q, digits_d;

  logic [ROWS-1:0] row_mask;
  logic            match;
  logic            confirm;
  logic            release_done;
  logic [1:0]      conf_row;
  logic [1:0]      low_row;
  logic [3:0]      new_code;

  always_comb begin
    low_row = 2'd3;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!rs_q[i]) low_row = 2'(i);
    end
  end

  // A match needs the captured row alone to be low; a second row low breaks it.
  assign row_mask = 4'b0001 << row_q;
  assign match    = (rs_q == ~row_mask);

  always_comb begin
    state_d      = state_q;
    sync1_d      = row_in;
    rs_d         = sync1_q;
    col_d        = col_q;
    row_d        = row_q;
    deb_d        = deb_q;
    key_valid_d  = 1'b0;
    key_code_d   = key_code_q;
    key_held_d   = key_held_q;
    digits_d     = digits_q;
    confirm      = 1'b0;
    release_done = 1'b0;
    conf_row     = row_q;

    if (tick) begin
      case (state_q)
        SCAN: begin
          if (rs_q == 4'hF) begin
            col_d = col_q + 2'd1;
          end else begin
            row_d    = low_row;
            conf_row = low_row;
            deb_d    = 4'd1;
            if (DEB_N == 4'd1) confirm = 1'b1;
            else               state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (match) begin
            deb_d = deb_q + 4'd1;
            if (deb_d == DEB_N) confirm = 1'b1;
          end else begin
            state_d = SCAN;
            col_d   = col_q + 2'd1;
          end
        end
        HELD: begin
          if (rs_q[row_q]) begin
            deb_d = 4'd1;
            if (DEB_N == 4'd1) release_done = 1'b1;
            else               state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (rs_q[row_q]) begin
            deb_d = deb_q + 4'd1;
            if (deb_d == DEB_N) release_done = 1'b1;
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end

    new_code = key_lookup(conf_row, col_q);
    if (confirm) begin
      key_valid_d = 1'b1;
      key_code_d  = new_code;
      digits_d    = {digits_q[11:0], new_code};
      key_held_d  = 1'b1;
      state_d     = HELD;
    end
    if (release_done) begin
      key_held_d = 1'b0;
      col_d      = col_q + 2'd1;
      state_d    = SCAN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      sync1_q     <= 4'hF;
      rs_q        <= 4'hF;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      deb_q       <= 4'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      key_held_q  <= 1'b0;
      digits_q    <= 16'h0000;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      rs_q        <= rs_d;
      col_q       <= col_d;
      row_q       <= row_d;
      deb_q       <= deb_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
      digits_q    <= digits_d;
    end
  end

  assign col_out   = ~(4'b0001 << col_q);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;
  assign digits    = digits_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// +-----------------------------------------------------------------------+
// | tb_keypad_scanner : directed bench with a behavioural keypad model    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] digits;

  logic        press_en  = 1'b0;
  logic [1:0]  press_row = 2'd0;
  logic [1:0]  press_col = 2'd0;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int b2b_cnt = 0;
  logic prev_kv = 1'b0;

  always #5 clk = ~clk;

  // A pressed key pulls its row low only while its column is driven.
  assign row_in = (press_en && (col_out[press_col] == 1'b0)) ? ~(4'b0001 << press_row) : 4'hF;

  keypad_scanner #(
    .CLK_HZ         (1000),
    .SCAN_HZ        (100),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .digits    (digits)
  );

  always @(negedge clk) begin
    if (key_valid) begin
      pulses = pulses + 1;
      if (prev_kv) b2b_cnt = b2b_cnt + 1;
    end
    prev_kv = key_valid;
  end

  task automatic do_reset;
    press_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (col_out !== 4'b1110) begin bad++; $display("FAIL reset_col_out got=%b want=1110", col_out); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_key_valid got=%b want=0", key_valid); end
    total++; if (key_code !== 4'h0) begin bad++; $display("FAIL reset_key_code got=%h want=0", key_code); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL reset_key_held got=%b want=0", key_held); end
    total++; if (digits !== 16'h0000) begin bad++; $display("FAIL reset_digits got=%h want=0000", digits); end
  endtask

  task automatic test_idle;
    int p0;
    logic [3:0] exp_col;
    do_reset();
    p0 = pulses;
    for (int p = 1; p <= 100; p++) begin
      @(posedge clk); #1;
      if (p % 10 == 5) begin
        exp_col = ~(4'b0001 << ((p / 10) % 4));
        total++;
        if (col_out !== exp_col) begin bad++; $display("FAIL idle_col p=%0d got=%b want=%b", p, col_out, exp_col); end
      end
    end
    total++; if (pulses - p0 != 0) begin bad++; $display("FAIL idle_pulses got=%0d want=0", pulses - p0); end
    total++; if (digits !== 16'h0000) begin bad++; $display("FAIL idle_digits got=%h want=0000", digits); end
  endtask

  task automatic test_single_key;
    int p0;
    do_reset();
    press_row = 2'd1; press_col = 2'd2; press_en = 1'b1;
    p0 = pulses;
    for (int p = 1; p <= 110; p++) begin
      @(posedge clk); #1;
      if (p == 49) begin total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL k6_early_valid got=%b want=0", key_valid); end end
      if (p == 50) begin total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL k6_valid_latency got=%b want=1", key_valid); end end
      if (p == 51) begin total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL k6_valid_width got=%b want=0", key_valid); end end
      if (p == 60) begin
        total++; if (pulses - p0 != 1) begin bad++; $display("FAIL k6_pulses got=%0d want=1", pulses - p0); end
        total++; if (key_code !== 4'h6) begin bad++; $display("FAIL k6_code got=%h want=6", key_code); end
        total++; if (digits !== 16'h0006) begin bad++; $display("FAIL k6_digits got=%h want=0006", digits); end
        total++; if (key_held !== 1'b1) begin bad++; $display("FAIL k6_held got=%b want=1", key_held); end
        press_en = 1'b0;
      end
      if (p == 85) begin total++; if (key_held !== 1'b1) begin bad++; $display("FAIL k6_held_release got=%b want=1", key_held); end end
      if (p == 90) begin total++; if (key_held !== 1'b0) begin bad++; $display("FAIL k6_held_drop got=%b want=0", key_held); end end
      if (p == 95) begin total++; if (col_out !== 4'b0111) begin bad++; $display("FAIL k6_resume_col got=%b want=0111", col_out); end end
      if (p == 105) begin total++; if (col_out !== 4'b1110) begin bad++; $display("FAIL k6_wrap_col got=%b want=1110", col_out); end end
    end
  endtask

  task automatic test_sequence;
    int p0;
    logic seen;
    logic [1:0] krow [4];
    logic [1:0] kcol [4];
    krow = '{2'd0, 2'd0, 2'd0, 2'd3};
    kcol = '{2'd0, 2'd1, 2'd2, 2'd2};
    do_reset();
    p0 = pulses;
    for (int k = 0; k < 4; k++) begin
      press_row = krow[k]; press_col = kcol[k]; press_en = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
        @(posedge clk); #1;
        if (key_valid) seen = 1'b1;
      end
      total++; if (!seen) begin bad++; $display("FAIL seq_press_timeout key=%0d got=none want=key_valid", k); end
      press_en = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
        @(posedge clk); #1;
        if (!key_held) seen = 1'b1;
      end
      total++; if (!seen) begin bad++; $display("FAIL seq_release_timeout key=%0d got=held want=released", k); end
    end
    total++; if (digits !== 16'h123F) begin bad++; $display("FAIL seq_digits got=%h want=123f", digits); end
    total++; if (key_code !== 4'hF) begin bad++; $display("FAIL seq_code got=%h want=f", key_code); end
    total++; if (pulses - p0 != 4) begin bad++; $display("FAIL seq_pulses got=%0d want=4", pulses - p0); end
  endtask

  task automatic test_bounce;
    int p0;
    do_reset();
    press_row = 2'd0; press_col = 2'd0; press_en = 1'b1;
    p0 = pulses;
    for (int p = 1; p <= 200; p++) begin
      @(posedge clk); #1;
      press_en = ((p / 10) % 2 == 0);
      if (p == 25) begin total++; if (col_out !== 4'b1101) begin bad++; $display("FAIL bounce_rescan got=%b want=1101", col_out); end end
    end
    press_en = 1'b0;
    total++; if (pulses - p0 != 0) begin bad++; $display("FAIL bounce_pulses got=%0d want=0", pulses - p0); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL bounce_held got=%b want=0", key_held); end
  endtask

  task automatic test_release_chatter;
    int p0;
    do_reset();
    press_row = 2'd2; press_col = 2'd2; press_en = 1'b1;
    p0 = pulses;
    for (int p = 1; p <= 160; p++) begin
      @(posedge clk); #1;
      if (p < 60)       press_en = 1'b1;
      else if (p < 120) press_en = ((p / 10) % 2 == 1);
      else              press_en = 1'b0;
      if (p == 55) begin total++; if (key_code !== 4'h9) begin bad++; $display("FAIL chat_code got=%h want=9", key_code); end end
      if (p == 119) begin total++; if (key_held !== 1'b1) begin bad++; $display("FAIL chat_held_mid got=%b want=1", key_held); end end
      if (p == 145) begin total++; if (key_held !== 1'b1) begin bad++; $display("FAIL chat_held_late got=%b want=1", key_held); end end
      if (p == 150) begin total++; if (key_held !== 1'b0) begin bad++; $display("FAIL chat_held_drop got=%b want=0", key_held); end end
    end
    total++; if (pulses - p0 != 1) begin bad++; $display("FAIL chat_pulses got=%0d want=1", pulses - p0); end
  endtask

  task automatic test_reset_mid_debounce;
    int p0;
    do_reset();
    press_row = 2'd1; press_col = 2'd1; press_en = 1'b1;
    p0 = pulses;
    for (int p = 1; p <= 35; p++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (col_out !== 4'b1110) begin bad++; $display("FAIL rstmid_col got=%b want=1110", col_out); end
    total++; if (digits !== 16'h0000) begin bad++; $display("FAIL rstmid_digits got=%h want=0000", digits); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL rstmid_held got=%b want=0", key_held); end
    press_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    total++; if (pulses - p0 != 0) begin bad++; $display("FAIL rstmid_pulses got=%0d want=0", pulses - p0); end
    total++; if (digits !== 16'h0000) begin bad++; $display("FAIL rstmid_digits_after got=%h want=0000", digits); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_key();
    test_sequence();
    test_bounce();
    test_release_chatter();
    test_reset_mid_debounce();
    total++; if (b2b_cnt != 0) begin bad++; $display("FAIL valid_back_to_back got=%0d want=0", b2b_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
